// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR definitions for the counter file: SYSTEM funct3 ops, counter CSR addresses
// and the read/set/clear write-value helper.
package csr_counter_unit_pkg;

    typedef enum logic [2:0] {
        FUNCT3_PRIV = 3'b000,
        CSRRW       = 3'b001,
        CSRRS       = 3'b010,
        CSRRC       = 3'b011,
        CSRRWI      = 3'b101,
        CSRRSI      = 3'b110,
        CSRRCI      = 3'b111
    } funct3_system_t;

    typedef enum logic [11:0] {
        CSR_REG_MCOUNTINHIBIT  = 12'h320,
        CSR_REG_MCYCLE         = 12'hB00,
        CSR_REG_MINSTRET       = 12'hB02,
        CSR_REG_MHPMCOUNTER3   = 12'hB03,
        CSR_REG_MCYCLEH        = 12'hB80,
        CSR_REG_MINSTRETH      = 12'hB82,
        CSR_REG_MHPMCOUNTER3H  = 12'hB83,
        CSR_REG_CYCLE          = 12'hC00,
        CSR_REG_TIME           = 12'hC01,
        CSR_REG_INSTRET        = 12'hC02,
        CSR_REG_HPMCOUNTER3    = 12'hC03,
        CSR_REG_CYCLEH         = 12'hC80,
        CSR_REG_TIMEH          = 12'hC81,
        CSR_REG_INSTRETH       = 12'hC82,
        CSR_REG_HPMCOUNTER3H   = 12'hC83
    } csr_reg_t;

    localparam int CSR_HPM_FIRST = 3;
    localparam int CSR_HPM_MAX   = 29;

    function automatic logic [31:0] csr_new_value(input funct3_system_t op,
                                                  input logic [31:0] old_val,
                                                  input logic [31:0] wdata);
        case (op)
            CSRRW, CSRRWI: return wdata;
            CSRRS, CSRRSI: return old_val | wdata;
            CSRRC, CSRRCI: return old_val & ~wdata;
            default:       return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_unit_if.sv
// CSR access channel between the SYSTEM path (master) and the counter file (slave).
// Request is a single-cycle pulse; the response follows exactly one cycle later.
interface csr_counter_unit_if;
    import csr_counter_unit_pkg::*;

    logic           csr_req_i;
    logic [11:0]    csr_addr_i;
    funct3_system_t csr_op_i;
    logic [31:0]    csr_wdata_i;
    logic           csr_wr_en_i;
    logic           csr_rsp_valid_o;
    logic [31:0]    csr_rdata_o;
    logic           csr_illegal_o;

    modport master (
        output csr_req_i, csr_addr_i, csr_op_i, csr_wdata_i, csr_wr_en_i,
        input  csr_rsp_valid_o, csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_req_i, csr_addr_i, csr_op_i, csr_wdata_i, csr_wr_en_i,
        output csr_rsp_valid_o, csr_rdata_o, csr_illegal_o
    );

endinterface

// File: rtl/csr_counter.sv
// One CNT_WIDTH event counter with 32-bit half writes; a write in the same cycle
// as an increment wins and the increment is dropped. Update visible next cycle.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 inc_i,
    input  logic                 inhibit_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          cur64, wr64;
    logic                 unused_wr_bits;

    // Writes merge at 64 bits; anything above CNT_WIDTH is simply dropped.
    assign cur64          = 64'(cnt_q);
    assign wr64           = {wr_hi_i ? wdata_i : cur64[63:32], wr_lo_i ? wdata_i : cur64[31:0]};
    assign unused_wr_bits = ^wr64;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            cnt_d = wr64[CNT_WIDTH-1:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Performance counter CSR file: cycle, time, instret, NUM_HPM hpm counters and mcountinhibit.
// Registered response one cycle after each request; no backpressure, one request per cycle.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter  int NUM_HPM   = 4,
    parameter  int CNT_WIDTH = 64,
    parameter  int TIME_DIV  = 1,
    localparam int HPM_W     = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    csr_counter_unit_if.slave csr,
    input  logic              instret_i,
    input  logic [HPM_W-1:0]  hpm_event_i
);
    localparam int          NCNT     = CSR_HPM_FIRST + NUM_HPM;
    localparam int          PW       = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [63:0] NMASK    = (64'd1 << NCNT) - 64'd1;
    localparam logic [31:0] INH_MASK = NMASK[31:0] & ~32'h2;

    logic [PW-1:0]   presc_q, presc_d;
    logic            time_tick;
    logic [31:0]     inhibit_q;
    logic            rsp_valid_q, illegal_q;
    logic [31:0]     rdata_q;

    logic [4:0]      idx;
    logic            hi, user_rng, mach_rng, is_inh, op_ok, wr_req, idx_ok, legal, inh_wr;
    logic [31:0]     old_val, new_val;
    logic [NCNT-1:0] wr_lo, wr_hi;
    logic [63:0]     cnt_ext [NCNT];

    assign time_tick = (presc_q == PW'(TIME_DIV - 1));
    assign presc_d   = time_tick ? '0 : presc_q + PW'(1);

    // Counter CSRs share one index space: [4:0] picks the counter, [7] the half.
    always_comb begin
        idx      = csr.csr_addr_i[4:0];
        hi       = csr.csr_addr_i[7];
        user_rng = (csr.csr_addr_i[11:8] == 4'hC) && (csr.csr_addr_i[6:5] == 2'b00);
        mach_rng = (csr.csr_addr_i[11:8] == 4'hB) && (csr.csr_addr_i[6:5] == 2'b00);
        is_inh   = (csr.csr_addr_i == CSR_REG_MCOUNTINHIBIT);
        op_ok    = csr.csr_op_i inside {CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};
        wr_req   = csr.csr_wr_en_i || (csr.csr_op_i == CSRRW) || (csr.csr_op_i == CSRRWI);
        idx_ok   = int'(idx) < NCNT;
        legal    = op_ok && (is_inh
                            || (user_rng && idx_ok && !wr_req)
                            || (mach_rng && idx_ok && (idx != 5'd1)));

        old_val = '0;
        if (is_inh) begin
            old_val = inhibit_q;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                if (int'(idx) == k) begin
                    old_val = hi ? cnt_ext[k][63:32] : cnt_ext[k][31:0];
                end
            end
        end
        new_val = csr_new_value(csr.csr_op_i, old_val, csr.csr_wdata_i);

        inh_wr = 1'b0;
        wr_lo  = '0;
        wr_hi  = '0;
        if (csr.csr_req_i && legal && wr_req) begin
            if (is_inh) begin
                inh_wr = 1'b1;
            end else begin
                for (int k = 0; k < NCNT; k++) begin
                    if (int'(idx) == k) begin
                        wr_lo[k] = !hi;
                        wr_hi[k] = hi;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        logic                 inc, inh;
        logic [CNT_WIDTH-1:0] val;

        if (g == 0) begin : g_cycle
            assign inc = 1'b1;
            assign inh = inhibit_q[0];
        end else if (g == 1) begin : g_time
            assign inc = time_tick;
            assign inh = 1'b0;
        end else if (g == 2) begin : g_instret
            assign inc = instret_i;
            assign inh = inhibit_q[2];
        end else begin : g_hpm
            assign inc = hpm_event_i[g-CSR_HPM_FIRST];
            assign inh = inhibit_q[g];
        end

        csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i     (clk_i),
            .reset_ni  (reset_ni),
            .inc_i     (inc),
            .inhibit_i (inh),
            .wr_lo_i   (wr_lo[g]),
            .wr_hi_i   (wr_hi[g]),
            .wdata_i   (new_val),
            .cnt_o     (val)
        );

        assign cnt_ext[g] = 64'(val);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc_q     <= '0;
            inhibit_q   <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            rsp_valid_q <= csr.csr_req_i;
            if (inh_wr) begin
                inhibit_q <= new_val & INH_MASK;
            end
            if (csr.csr_req_i) begin
                rdata_q   <= legal ? old_val : 32'h0;
                illegal_q <= !legal;
            end
        end
    end

    assign csr.csr_rsp_valid_o = rsp_valid_q;
    assign csr.csr_rdata_o     = rdata_q;
    assign csr.csr_illegal_o   = illegal_q;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit (NUM_HPM=4, CNT_WIDTH=40, TIME_DIV=4).
// Inputs change on the falling edge; responses are sampled on the following falling edge.
module tb_csr_counter_unit;
    import csr_counter_unit_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       instret_i;
    logic [3:0] hpm_event_i;
    int         n_tests = 0;
    int         n_fail  = 0;

    csr_counter_unit_if bus ();

    csr_counter_unit #(.NUM_HPM(4), .CNT_WIDTH(40), .TIME_DIV(4)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .csr         (bus),
        .instret_i   (instret_i),
        .hpm_event_i (hpm_event_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: the request is accepted at the next rising edge.
    task automatic acc(input string tag, input logic [11:0] a, input funct3_system_t op,
                       input logic [31:0] wd, input logic we,
                       input logic [31:0] exp_d, input logic exp_ill);
        bus.csr_req_i   = 1'b1;
        bus.csr_addr_i  = a;
        bus.csr_op_i    = op;
        bus.csr_wdata_i = wd;
        bus.csr_wr_en_i = we;
        @(negedge clk_i);
        bus.csr_req_i   = 1'b0;
        bus.csr_wr_en_i = 1'b0;
        chk({tag, "_vld"}, 32'(bus.csr_rsp_valid_o), 32'd1);
        chk({tag, "_ill"}, 32'(bus.csr_illegal_o), 32'(exp_ill));
        chk({tag, "_dat"}, bus.csr_rdata_o, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_ni        = 1'b0;
        instret_i       = 1'b0;
        hpm_event_i     = 4'h0;
        bus.csr_req_i   = 1'b0;
        bus.csr_addr_i  = 12'h000;
        bus.csr_op_i    = CSRRS;
        bus.csr_wdata_i = 32'h0;
        bus.csr_wr_en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_vld", 32'(bus.csr_rsp_valid_o), 32'd0);
        chk("rst_dat", bus.csr_rdata_o, 32'd0);
        chk("rst_ill", 32'(bus.csr_illegal_o), 32'd0);

        reset_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("idle_vld", 32'(bus.csr_rsp_valid_o), 32'd0);
        acc("cycle10",  12'hC00, CSRRS, 32'h0, 1'b0, 32'd10, 1'b0);
        acc("time2",    12'hC01, CSRRS, 32'h0, 1'b0, 32'd2,  1'b0);

        // Carry into the high half, then a high-half write keeps the low half.
        acc("wr_mcyc",  12'hB00, CSRRW, 32'hFFFF_FFFF, 1'b1, 32'd12, 1'b0);
        @(negedge clk_i);
        acc("carry_hi", 12'hB80, CSRRS, 32'h0, 1'b0, 32'd1, 1'b0);
        acc("wr_hi",    12'hB80, CSRRW, 32'd5, 1'b1, 32'd1, 1'b0);
        acc("rd_hi5",   12'hB80, CSRRS, 32'h0, 1'b0, 32'd5, 1'b0);
        acc("rd_lo2",   12'hB00, CSRRS, 32'h0, 1'b0, 32'd2, 1'b0);

        // Inhibit cycle and instret.
        acc("wr_inh5",  12'h320, CSRRW, 32'h5, 1'b1, 32'd0, 1'b0);
        instret_i = 1'b1;
        repeat (3) @(negedge clk_i);
        instret_i = 1'b0;
        acc("inh_cyc1", 12'hC00, CSRRS, 32'h0, 1'b0, 32'd4, 1'b0);
        acc("inh_cyc2", 12'hC00, CSRRS, 32'h0, 1'b0, 32'd4, 1'b0);
        acc("inh_inst", 12'hC02, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("wr_inh2",  12'h320, CSRRW, 32'h2, 1'b1, 32'd5, 1'b0);
        acc("rd_inh0",  12'h320, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);

        // Illegal accesses, then a read-only set on a user alias.
        acc("ill_wc00", 12'hC00, CSRRW, 32'h1234, 1'b1, 32'd0, 1'b1);
        acc("ill_sc01", 12'hC01, CSRRS, 32'h1,    1'b1, 32'd0, 1'b1);
        acc("ill_c07",  12'hC07, CSRRS, 32'h0,    1'b0, 32'd0, 1'b1);
        acc("ro_c00",   12'hC00, CSRRS, 32'h0,    1'b0, 32'd8, 1'b0);

        // Write over increment.
        acc("wr_100",   12'hB00, CSRRW, 32'h100, 1'b1, 32'd9,    1'b0);
        acc("rd_100",   12'hB00, CSRRS, 32'h0,   1'b0, 32'h100,  1'b0);

        // hpm events and set/clear/immediate ops.
        hpm_event_i = 4'b0010;
        repeat (2) @(negedge clk_i);
        hpm_event_i = 4'b0000;
        acc("hpm4",     12'hC04, CSRRS,  32'h0,  1'b0, 32'd2,   1'b0);
        acc("hpm3",     12'hC03, CSRRS,  32'h0,  1'b0, 32'd0,   1'b0);
        instret_i = 1'b1;
        @(negedge clk_i);
        instret_i = 1'b0;
        acc("inst1",    12'hB02, CSRRS,  32'h0,  1'b0, 32'd1,   1'b0);
        acc("inst_set", 12'hB02, CSRRS,  32'h10, 1'b1, 32'd1,   1'b0);
        acc("inst_clr", 12'hB02, CSRRC,  32'h1,  1'b1, 32'h11,  1'b0);
        acc("inst10",   12'hC02, CSRRS,  32'h0,  1'b0, 32'h10,  1'b0);
        acc("hpm3_wi",  12'hB03, CSRRWI, 32'd7,  1'b1, 32'd0,   1'b0);
        acc("hpm3_7",   12'hC03, CSRRS,  32'h0,  1'b0, 32'd7,   1'b0);

        // Hardwired-zero inhibit bits; clearing costs cycle exactly one increment.
        acc("inh_all",  12'h320, CSRRW, 32'hFFFF_FFFF, 1'b1, 32'd0,    1'b0);
        acc("inh_mask", 12'h320, CSRRC, 32'hFFFF_FFFF, 1'b1, 32'h7D,   1'b0);

        // 40-bit wrap-around; high bits above CNT_WIDTH are discarded.
        acc("wr_hi_ff", 12'hB80, CSRRW, 32'hFFFF_FFFF, 1'b1, 32'd5,      1'b0);
        acc("wr_lo_ff", 12'hB00, CSRRW, 32'hFFFF_FFFF, 1'b1, 32'h10D,    1'b0);
        acc("ones_hi",  12'hB80, CSRRS, 32'h0, 1'b0, 32'hFF, 1'b0);
        acc("wrap_lo",  12'hB00, CSRRS, 32'h0, 1'b0, 32'h0,  1'b0);
        acc("wrap_hi",  12'hB80, CSRRS, 32'h0, 1'b0, 32'h0,  1'b0);

        // Reset between request and response.
        bus.csr_req_i   = 1'b1;
        bus.csr_addr_i  = 12'hC00;
        bus.csr_op_i    = CSRRS;
        bus.csr_wdata_i = 32'h0;
        #2 reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk("mid_rst_vld", 32'(bus.csr_rsp_valid_o), 32'd0);
        chk("mid_rst_dat", bus.csr_rdata_o, 32'd0);
        @(negedge clk_i);
        bus.csr_req_i = 1'b0;
        reset_ni      = 1'b1;
        acc("post_cyc",  12'hB00, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("post_inst", 12'hC02, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("post_inh",  12'h320, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("post_time", 12'hC01, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("post_hpm",  12'hB03, CSRRS, 32'h0, 1'b0, 32'd0, 1'b0);
        acc("ill_b01",   12'hB01, CSRRS, 32'h0, 1'b0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
